// File: rtl/tpu_pkg.sv
// rtl/tpu_pkg.sv - shared types, defaults and saturation helper for the tpu output path
package tpu_pkg;

   localparam int DATA_WIDTH_DEF = 8;
   localparam int ACC_WIDTH_DEF  = 32;
   localparam int SAT_W          = 64;

   typedef enum logic [1:0] {
      S_IDLE,
      S_LOAD,
      S_DRAIN,
      S_FIN
   } state_t;

   // Clamp a signed value into the range of a signed integer of the given width.
   function automatic logic signed [SAT_W-1:0] sat_signed(input logic signed [SAT_W-1:0] v,
                                                          input int width);
      logic signed [SAT_W-1:0] hi;
      logic signed [SAT_W-1:0] lo;
      hi = (SAT_W'(1) << (width - 1)) - SAT_W'(1);
      lo = ~hi;
      if (v > hi)
         sat_signed = hi;
      else if (v < lo)
         sat_signed = lo;
      else
         sat_signed = v;
   endfunction

endpackage

// File: rtl/tpu_requant_elem.sv
// rtl/tpu_requant_elem.sv - combinational requantizer: scale, round-half-up shift, relu, saturate
module tpu_requant_elem
   import tpu_pkg::*;
#(
   parameter int ACC_WIDTH   = ACC_WIDTH_DEF,
   parameter int SCALE_WIDTH = 16,
   parameter int DATA_WIDTH  = DATA_WIDTH_DEF
) (
   input  logic [ACC_WIDTH-1:0]   acc,
   input  logic [SCALE_WIDTH-1:0] scale,
   input  logic [5:0]             shift,
   input  logic                   relu_en,
   output logic [DATA_WIDTH-1:0]  data
);

   localparam int PW = ACC_WIDTH + SCALE_WIDTH + 1;

   logic signed [PW-1:0]    acc_x;
   logic signed [PW-1:0]    scl_x;
   logic signed [PW-1:0]    prod;
   logic signed [PW-1:0]    rnd;
   logic signed [PW-1:0]    shifted;
   logic        [PW-1:0]    one_pw;
   logic signed [SAT_W-1:0] ext;

   always_comb begin
      acc_x  = {{(PW-ACC_WIDTH){acc[ACC_WIDTH-1]}}, acc};
      scl_x  = {{(PW-SCALE_WIDTH){1'b0}}, scale};
      one_pw = {{(PW-1){1'b0}}, 1'b1};
      prod   = acc_x * scl_x;
      rnd    = prod;
      // Adding half an LSB before the arithmetic shift rounds ties toward +inf.
      if (shift != 6'd0)
         rnd = prod + $signed(one_pw << (shift - 6'd1));
      shifted = rnd >>> shift;
      if (relu_en && shifted[PW-1])
         shifted = '0;
      ext  = {{(SAT_W-PW){shifted[PW-1]}}, shifted};
      data = DATA_WIDTH'(sat_signed(ext, DATA_WIDTH));
   end

endmodule

// File: rtl/tpu_output_requant.sv
// rtl/tpu_output_requant.sv - snapshots the accumulator matrix and drains it requantized, row-major
module tpu_output_requant
   import tpu_pkg::*;
#(
   parameter int SIZE        = 4,
   parameter int DATA_WIDTH  = DATA_WIDTH_DEF,
   parameter int ACC_WIDTH   = ACC_WIDTH_DEF,
   parameter int SCALE_WIDTH = 16
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic                            c_valid,
   input  logic [SIZE*SIZE*ACC_WIDTH-1:0]  c_flat,
   input  logic [7:0]                      matrix_size,
   input  logic [SCALE_WIDTH-1:0]          scale_mult,
   input  logic [5:0]                      shift_amt,
   input  logic                            relu_en,
   output logic                            out_valid,
   input  logic                            out_ready,
   output logic [DATA_WIDTH-1:0]           out_data,
   output logic [7:0]                      out_row,
   output logic [7:0]                      out_col,
   output logic                            out_last,
   output logic                            busy,
   output logic                            drain_done,
   output logic                            overrun
);

   localparam int FLAT_W = SIZE * SIZE * ACC_WIDTH;
   localparam int OFF_W  = $clog2(FLAT_W);

   state_t                   state;
   state_t                   state_n;
   logic [FLAT_W-1:0]        snap;
   logic [SCALE_WIDTH-1:0]   scale_r;
   logic [5:0]               shift_r;
   logic                     relu_r;
   logic [7:0]               n_eff;
   logic [7:0]               n_cap;
   logic [7:0]               sel_row;
   logic [7:0]               sel_col;
   logic                     sel_last;
   logic                     load_out;
   logic                     handshake;
   logic [OFF_W-1:0]         bit_off;
   logic [DATA_WIDTH-1:0]    elem_data;

   assign n_cap     = (matrix_size > 8'(SIZE)) ? 8'(SIZE) : matrix_size;
   assign handshake = out_valid && out_ready;
   assign bit_off   = OFF_W'((32'(sel_row) * SIZE + 32'(sel_col)) * ACC_WIDTH);

   always_comb begin
      state_n  = state;
      sel_row  = out_row;
      sel_col  = out_col;
      load_out = 1'b0;
      case (state)
         S_IDLE:
            if (c_valid)
               state_n = (n_cap != 8'd0) ? S_LOAD : S_FIN;
         S_LOAD: begin
            sel_row  = 8'd0;
            sel_col  = 8'd0;
            load_out = 1'b1;
            state_n  = S_DRAIN;
         end
         S_DRAIN:
            if (handshake) begin
               if (out_last) begin
                  state_n = S_FIN;
               end else begin
                  load_out = 1'b1;
                  if (out_col == n_eff - 8'd1) begin
                     sel_row = out_row + 8'd1;
                     sel_col = 8'd0;
                  end else begin
                     sel_col = out_col + 8'd1;
                  end
               end
            end
         S_FIN:
            state_n = S_IDLE;
         default:
            state_n = S_IDLE;
      endcase
      sel_last = (sel_row == n_eff - 8'd1) && (sel_col == n_eff - 8'd1);
   end

   tpu_requant_elem #(
      .ACC_WIDTH  (ACC_WIDTH),
      .SCALE_WIDTH(SCALE_WIDTH),
      .DATA_WIDTH (DATA_WIDTH)
   ) u_elem (
      .acc    (snap[bit_off +: ACC_WIDTH]),
      .scale  (scale_r),
      .shift  (shift_r),
      .relu_en(relu_r),
      .data   (elem_data)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= S_IDLE;
         scale_r    <= '0;
         shift_r    <= '0;
         relu_r     <= 1'b0;
         n_eff      <= '0;
         out_valid  <= 1'b0;
         out_data   <= '0;
         out_row    <= '0;
         out_col    <= '0;
         out_last   <= 1'b0;
         busy       <= 1'b0;
         drain_done <= 1'b0;
         overrun    <= 1'b0;
      end else begin
         state      <= state_n;
         drain_done <= 1'b0;
         if (c_valid) begin
            if (state == S_IDLE) begin
               snap    <= c_flat;
               scale_r <= scale_mult;
               shift_r <= shift_amt;
               relu_r  <= relu_en;
               n_eff   <= n_cap;
               busy    <= 1'b1;
            end else begin
               overrun <= 1'b1;
            end
         end
         if (load_out) begin
            out_valid <= 1'b1;
            out_data  <= elem_data;
            out_row   <= sel_row;
            out_col   <= sel_col;
            out_last  <= sel_last;
         end else if (state == S_DRAIN && handshake && out_last) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
         end
         if (state == S_FIN) begin
            drain_done <= 1'b1;
            busy       <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_tpu_output_requant.sv
// tb/tb_tpu_output_requant.sv - directed self-checking bench for tpu_output_requant
module tb_tpu_output_requant;

   logic         clk;
   logic         rst;
   logic         c_valid;
   logic [511:0] c_flat;
   logic [7:0]   matrix_size;
   logic [15:0]  scale_mult;
   logic [5:0]   shift_amt;
   logic         relu_en;
   logic         out_valid;
   logic         out_ready;
   logic [7:0]   out_data;
   logic [7:0]   out_row;
   logic [7:0]   out_col;
   logic         out_last;
   logic         busy;
   logic         drain_done;
   logic         overrun;

   int checks = 0;
   int errors = 0;

   logic signed [31:0] cm [16];
   logic [24:0]        beats [$];
   logic [23:0]        stall_q [$];
   int                 first_valid;
   int                 done_seen;
   logic               busy0;

   tpu_output_requant dut (
      .clk        (clk),
      .rst        (rst),
      .c_valid    (c_valid),
      .c_flat     (c_flat),
      .matrix_size(matrix_size),
      .scale_mult (scale_mult),
      .shift_amt  (shift_amt),
      .relu_en    (relu_en),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_data   (out_data),
      .out_row    (out_row),
      .out_col    (out_col),
      .out_last   (out_last),
      .busy       (busy),
      .drain_done (drain_done),
      .overrun    (overrun)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic logic [24:0] bw(input int d, input int r, input int c, input bit l);
      return {8'(d), 8'(r), 8'(c), l};
   endfunction

   task automatic clear_c();
      for (int k = 0; k < 16; k++) cm[k] = 0;
   endtask

   task automatic ramp_c();
      for (int k = 0; k < 16; k++) cm[k] = k;
   endtask

   task automatic start(input logic [7:0] n, input logic [15:0] sc, input logic [5:0] sh, input logic rl);
      for (int k = 0; k < 16; k++) c_flat[k*32 +: 32] = cm[k];
      matrix_size = n;
      scale_mult  = sc;
      shift_amt   = sh;
      relu_en     = rl;
      c_valid     = 1'b1;
      @(negedge clk);
      c_valid     = 1'b0;
   endtask

   task automatic run_drain(input int stall_at, input int stall_len, input int ovr_at);
      int stalled = 0;
      beats.delete();
      stall_q.delete();
      first_valid = -1;
      done_seen   = -1;
      busy0       = busy;
      for (int cyc = 0; cyc < 80; cyc++) begin
         c_valid = (cyc == ovr_at);
         if (cyc == ovr_at) begin
            c_flat      = '1;
            matrix_size = 8'd1;
         end
         if (out_valid && first_valid < 0) first_valid = cyc;
         if (drain_done) begin
            done_seen = cyc;
            break;
         end
         out_ready = 1'b1;
         if (out_valid && beats.size() == stall_at && stalled < stall_len) begin
            out_ready = 1'b0;
            stalled++;
            stall_q.push_back({out_data, out_row, out_col});
         end
         if (out_valid && out_ready) beats.push_back({out_data, out_row, out_col, out_last});
         @(negedge clk);
      end
      c_valid   = 1'b0;
      out_ready = 1'b1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (2) @(negedge clk);
      checks++;
      if ({out_valid, out_last, busy, drain_done, overrun, out_data, out_row, out_col} !== '0) begin
         errors++;
         $display("FAIL reset_outputs got v=%0b d=%0d busy=%0b ovr=%0b want all zero",
                  out_valid, out_data, busy, overrun);
      end
      rst = 1'b0;
      @(negedge clk);
      checks++;
      if ({out_valid, busy, drain_done, overrun} !== 4'b0) begin
         errors++;
         $display("FAIL reset_idle got v=%0b busy=%0b done=%0b ovr=%0b want 0",
                  out_valid, busy, drain_done, overrun);
      end
   endtask

   task automatic test_saturation();
      logic [24:0] exp_b [4];
      exp_b = '{bw(100, 0, 0, 0), bw(127, 0, 1, 0), bw(-128, 1, 0, 0), bw(-5, 1, 1, 1)};
      clear_c();
      cm[0] = 100; cm[1] = 300; cm[4] = -300; cm[5] = -5;
      start(8'd2, 16'd1, 6'd0, 1'b0);
      run_drain(-1, 0, -1);
      checks++;
      if (beats.size() != 4) begin
         errors++;
         $display("FAIL sat_count got %0d want 4", beats.size());
      end
      for (int k = 0; k < 4 && k < beats.size(); k++) begin
         checks++;
         if (beats[k] !== exp_b[k]) begin
            errors++;
            $display("FAIL sat_beat%0d got %h want %h", k, beats[k], exp_b[k]);
         end
      end
      checks++;
      if (first_valid != 1) begin
         errors++;
         $display("FAIL sat_latency got %0d want 1", first_valid);
      end
      checks++;
      if (done_seen != 6) begin
         errors++;
         $display("FAIL sat_done_cycle got %0d want 6", done_seen);
      end
      checks++;
      if (busy0 !== 1'b1 || busy !== 1'b0) begin
         errors++;
         $display("FAIL sat_busy got %0b/%0b want 1/0", busy0, busy);
      end
      @(negedge clk);
      checks++;
      if (drain_done !== 1'b0) begin
         errors++;
         $display("FAIL sat_done_pulse got %0b want 0", drain_done);
      end
   endtask

   task automatic test_rounding();
      logic [24:0] exp_b [4];
      exp_b = '{bw(4, 0, 0, 0), bw(-4, 0, 1, 0), bw(2, 1, 0, 0), bw(5, 1, 1, 1)};
      clear_c();
      cm[0] = 5; cm[1] = -5; cm[4] = 2; cm[5] = 6;
      start(8'd2, 16'd3, 6'd2, 1'b0);
      run_drain(-1, 0, -1);
      checks++;
      if (beats.size() != 4) begin
         errors++;
         $display("FAIL round_count got %0d want 4", beats.size());
      end
      for (int k = 0; k < 4 && k < beats.size(); k++) begin
         checks++;
         if (beats[k] !== exp_b[k]) begin
            errors++;
            $display("FAIL round_beat%0d got %h want %h", k, beats[k], exp_b[k]);
         end
      end
      clear_c();
      cm[0] = 2;
      start(8'd1, 16'd1, 6'd2, 1'b0);
      run_drain(-1, 0, -1);
      checks++;
      if (beats.size() != 1 || beats[0] !== bw(1, 0, 0, 1)) begin
         errors++;
         $display("FAIL round_single got n=%0d %h want 1 beat %h", beats.size(),
                  (beats.size() > 0) ? beats[0] : 25'h0, bw(1, 0, 0, 1));
      end
   endtask

   task automatic test_relu();
      logic [24:0] exp_b [4];
      exp_b = '{bw(0, 0, 0, 0), bw(7, 0, 1, 0), bw(0, 1, 0, 0), bw(0, 1, 1, 1)};
      clear_c();
      cm[0] = -7; cm[1] = 7; cm[4] = 0; cm[5] = -128;
      start(8'd2, 16'd1, 6'd0, 1'b1);
      run_drain(-1, 0, -1);
      checks++;
      if (beats.size() != 4) begin
         errors++;
         $display("FAIL relu_count got %0d want 4", beats.size());
      end
      for (int k = 0; k < 4 && k < beats.size(); k++) begin
         checks++;
         if (beats[k] !== exp_b[k]) begin
            errors++;
            $display("FAIL relu_beat%0d got %h want %h", k, beats[k], exp_b[k]);
         end
      end
   endtask

   task automatic test_backpressure();
      ramp_c();
      start(8'd4, 16'd1, 6'd0, 1'b0);
      run_drain(5, 3, -1);
      checks++;
      if (stall_q.size() != 3) begin
         errors++;
         $display("FAIL bp_stall_len got %0d want 3", stall_q.size());
      end
      foreach (stall_q[k]) begin
         checks++;
         if (stall_q[k] !== {8'd5, 8'd1, 8'd1}) begin
            errors++;
            $display("FAIL bp_hold%0d got %h want %h", k, stall_q[k], {8'd5, 8'd1, 8'd1});
         end
      end
      checks++;
      if (beats.size() != 16) begin
         errors++;
         $display("FAIL bp_count got %0d want 16", beats.size());
      end
      for (int k = 0; k < 16 && k < beats.size(); k++) begin
         checks++;
         if (beats[k] !== bw(k, k / 4, k % 4, k == 15)) begin
            errors++;
            $display("FAIL bp_beat%0d got %h want %h", k, beats[k], bw(k, k / 4, k % 4, k == 15));
         end
      end
   endtask

   task automatic test_size_clamp();
      ramp_c();
      start(8'd9, 16'd1, 6'd0, 1'b0);
      run_drain(-1, 0, -1);
      checks++;
      if (beats.size() != 16) begin
         errors++;
         $display("FAIL clamp_count got %0d want 16", beats.size());
      end
      checks++;
      if (beats.size() == 16 && beats[15] !== bw(15, 3, 3, 1)) begin
         errors++;
         $display("FAIL clamp_last got %h want %h", beats[15], bw(15, 3, 3, 1));
      end
   endtask

   task automatic test_empty();
      ramp_c();
      start(8'd0, 16'd1, 6'd0, 1'b0);
      run_drain(-1, 0, -1);
      checks++;
      if (first_valid != -1 || beats.size() != 0) begin
         errors++;
         $display("FAIL empty_valid got first=%0d n=%0d want none", first_valid, beats.size());
      end
      checks++;
      if (done_seen != 1) begin
         errors++;
         $display("FAIL empty_done_cycle got %0d want 1", done_seen);
      end
   endtask

   task automatic test_overrun();
      checks++;
      if (overrun !== 1'b0) begin
         errors++;
         $display("FAIL ovr_initial got %0b want 0", overrun);
      end
      ramp_c();
      start(8'd4, 16'd1, 6'd0, 1'b0);
      run_drain(-1, 0, 5);
      checks++;
      if (overrun !== 1'b1) begin
         errors++;
         $display("FAIL ovr_flag got %0b want 1", overrun);
      end
      checks++;
      if (beats.size() != 16) begin
         errors++;
         $display("FAIL ovr_count got %0d want 16", beats.size());
      end
      for (int k = 0; k < 16 && k < beats.size(); k++) begin
         checks++;
         if (beats[k] !== bw(k, k / 4, k % 4, k == 15)) begin
            errors++;
            $display("FAIL ovr_beat%0d got %h want %h", k, beats[k], bw(k, k / 4, k % 4, k == 15));
         end
      end
   endtask

   task automatic test_reset_mid_drain();
      logic seen;
      ramp_c();
      start(8'd4, 16'd1, 6'd0, 1'b0);
      out_ready = 1'b1;
      repeat (4) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      checks++;
      if ({out_valid, out_last, busy, drain_done, overrun, out_data, out_row, out_col} !== '0) begin
         errors++;
         $display("FAIL mid_reset_outputs got v=%0b d=%0d r=%0d c=%0d busy=%0b ovr=%0b want all zero",
                  out_valid, out_data, out_row, out_col, busy, overrun);
      end
      rst  = 1'b0;
      seen = 1'b0;
      repeat (5) begin
         @(negedge clk);
         seen = seen | drain_done | out_valid;
      end
      checks++;
      if (seen !== 1'b0) begin
         errors++;
         $display("FAIL mid_reset_quiet got %0b want 0", seen);
      end
      clear_c();
      cm[0] = 42; cm[1] = 43;
      start(8'd2, 16'd1, 6'd0, 1'b0);
      run_drain(-1, 0, -1);
      checks++;
      if (beats.size() != 4 || beats[0] !== bw(42, 0, 0, 0) || beats[1] !== bw(43, 0, 1, 0)) begin
         errors++;
         $display("FAIL mid_reset_fresh got n=%0d first=%h want 4 beats from %h", beats.size(),
                  (beats.size() > 0) ? beats[0] : 25'h0, bw(42, 0, 0, 0));
      end
   endtask

   initial begin
      rst         = 1'b1;
      c_valid     = 1'b0;
      c_flat      = '0;
      matrix_size = 8'd0;
      scale_mult  = 16'd0;
      shift_amt   = 6'd0;
      relu_en     = 1'b0;
      out_ready   = 1'b1;
      @(negedge clk);
      test_reset();
      test_saturation();
      test_rounding();
      test_relu();
      test_backpressure();
      test_size_clamp();
      test_empty();
      test_overrun();
      test_reset_mid_drain();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
